time_set_editor: RTL

- Button-driven editor that produces the load interface (set_value1/10/100/1000, load_enable) consumed by the loadable mm:ss counters.
- Captures the live mm:ss digits on entry, lets the user step through the digits and increment or decrement each one with per-digit wrap, then issues a single-cycle load pulse on commit.
- Sits between the button edge detectors and the loadable up/down dec-60 counters.
- Driven by the 1 ms tick from the clock divider chain for blink and timeout.

---
 rtl/time_set_editor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/time_set_editor.sv
// time_set_editor: button-driven mm:ss editor.
// It captures the live counter digits when edit mode starts.
// In edit mode one digit is selected at a time and can be stepped up or down, wrapping per digit.
// On commit it drives a one-cycle load strobe into the loadable counters.
// clk_msec drives the blink of the selected digit and an inactivity timeout that leaves edit mode.
module time_set_editor #(
    parameter int BLINK_MS   = 250,
    parameter int TIMEOUT_MS = 10000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       clk_msec,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [3:0] cur_value1,
    input  logic [3:0] cur_value10,
    input  logic [3:0] cur_value100,
    input  logic [3:0] cur_value1000,
    output logic [3:0] set_value1,
    output logic [3:0] set_value10,
    output logic [3:0] set_value100,
    output logic [3:0] set_value1000,
    output logic       load_enable,
    output logic       edit_active,
    output logic [1:0] edit_digit,
    output logic       blink
);

    localparam int BW = (BLINK_MS   > 1) ? $clog2(BLINK_MS)   : 1;
    localparam int TW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EDIT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Digit 0 = seconds units ... digit 3 = minutes tens.
    logic [3:0][3:0] r_dig;
    logic [3:0][3:0] w_dig_nxt;
    logic [1:0]      r_sel;
    logic [1:0]      w_sel_nxt;
    logic            r_load;
    logic            w_load_nxt;
    logic            r_blink;
    logic            w_blink_nxt;
    logic [BW-1:0]   r_bcnt;
    logic [BW-1:0]   w_bcnt_nxt;
    logic [TW-1:0]   r_tcnt;
    logic [TW-1:0]   w_tcnt_nxt;

    logic            w_any_btn;
    logic [3:0]      w_lim;
    logic [3:0]      w_cur_dig;

    // Step up with wrap; a captured value already above the limit also wraps to 0.
    function automatic logic [3:0] f_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? 4'd0 : v + 4'd1;
    endfunction

    // Step down with wrap from 0 to the limit; out-of-range values just decrement.
    function automatic logic [3:0] f_dec(input logic [3:0] v, input logic [3:0] lim);
        return (v == 4'd0) ? lim : v - 4'd1;
    endfunction

    assign w_any_btn = btn_mode | btn_next | btn_inc | btn_dec;
    // The tens digits (1 and 3) count 0..5; the units digits count 0..9.
    assign w_lim     = r_sel[0] ? 4'd5 : 4'd9;
    assign w_cur_dig = r_dig[r_sel];

    // State register
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state and datapath updates; the highest-priority button wins, the others are dropped
    always_comb begin
        w_state_nxt = r_state;
        w_dig_nxt   = r_dig;
        w_sel_nxt   = r_sel;
        w_load_nxt  = 1'b0;
        w_blink_nxt = r_blink;
        w_bcnt_nxt  = r_bcnt;
        w_tcnt_nxt  = r_tcnt;

        case (r_state)
            S_IDLE: begin
                w_blink_nxt = 1'b1;
                w_bcnt_nxt  = '0;
                w_tcnt_nxt  = '0;
                if (btn_mode) begin
                    w_dig_nxt   = {cur_value1000, cur_value100, cur_value10, cur_value1};
                    w_sel_nxt   = 2'd0;
                    w_state_nxt = S_EDIT;
                end
            end

            S_EDIT: begin
                // Blink half-period tracking runs independently of button activity.
                if (clk_msec) begin
                    if (r_bcnt == BW'(BLINK_MS - 1)) begin
                        w_bcnt_nxt  = '0;
                        w_blink_nxt = ~r_blink;
                    end else begin
                        w_bcnt_nxt = r_bcnt + BW'(1);
                    end
                end

                // Inactivity timeout: the tick that would bring the count to TIMEOUT_MS-1 exits.
                if (w_any_btn) begin
                    w_tcnt_nxt = '0;
                end else if (clk_msec) begin
                    if (r_tcnt == TW'(TIMEOUT_MS - 2)) begin
                        w_tcnt_nxt  = '0;
                        w_bcnt_nxt  = '0;
                        w_blink_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tcnt_nxt = r_tcnt + TW'(1);
                    end
                end

                if (btn_mode) begin
                    // The strobe is registered so set_value* is already stable in the load cycle.
                    w_load_nxt  = 1'b1;
                    w_blink_nxt = 1'b1;
                    w_bcnt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else if (btn_next) begin
                    w_sel_nxt   = r_sel + 2'd1;
                    w_blink_nxt = 1'b1;
                    w_bcnt_nxt  = '0;
                end else if (btn_inc) begin
                    w_dig_nxt[r_sel] = f_inc(w_cur_dig, w_lim);
                end else if (btn_dec) begin
                    w_dig_nxt[r_sel] = f_dec(w_cur_dig, w_lim);
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers; reset clears everything except blink, which resets to "show"
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_dig   <= '0;
            r_sel   <= 2'd0;
            r_load  <= 1'b0;
            r_blink <= 1'b1;
            r_bcnt  <= '0;
            r_tcnt  <= '0;
        end else begin
            r_dig   <= w_dig_nxt;
            r_sel   <= w_sel_nxt;
            r_load  <= w_load_nxt;
            r_blink <= w_blink_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    assign set_value1    = r_dig[0];
    assign set_value10   = r_dig[1];
    assign set_value100  = r_dig[2];
    assign set_value1000 = r_dig[3];
    assign load_enable   = r_load;
    assign edit_active   = (r_state == S_EDIT);
    assign edit_digit    = r_sel;
    assign blink         = r_blink;

endmodule
